// File: rtl/bp_cce_pkg.sv
// Coherence-state encodings and directory entry layout shared by the CCE directory blocks.
package bp_cce_pkg;

   localparam int bp_cce_coh_bits       = 3;
   localparam int bp_cce_coh_shared_bit = 0;

   // Shared bit is clear in E and M, so "exclusive" is just valid-and-not-shared.
   typedef enum logic [bp_cce_coh_bits-1:0] {
      e_COH_I = 3'b000,
      e_COH_S = 3'b001,
      e_COH_E = 3'b010,
      e_COH_M = 3'b110
   } bp_coh_state_e;

endpackage

`ifndef DECLARE_BP_CCE_DIR_ENTRY_S
`define DECLARE_BP_CCE_DIR_ENTRY_S
`define BP_CCE_DECLARE_DIR_ENTRY_S(tag_width_mp) \
   typedef struct packed { \
      logic [tag_width_mp-1:0]                  tag; \
      logic [bp_cce_pkg::bp_cce_coh_bits-1:0]   state; \
   } dir_entry_s
`endif

// File: rtl/bp_cce_dir_lru_row_select.sv
// Combinational pick of one {tag,state} entry out of a packed [set][way] directory row.
module bp_cce_dir_lru_row_select
   import bp_cce_pkg::*;
#(
   parameter int lce_assoc_p        = 8,
   parameter int tag_sets_per_row_p = 2,
   parameter int tag_width_p        = 20,
   parameter int row_width_p        = tag_sets_per_row_p*lce_assoc_p*(tag_width_p+bp_cce_coh_bits),
   localparam int set_w_lp = (tag_sets_per_row_p > 1) ? $clog2(tag_sets_per_row_p) : 1,
   localparam int way_w_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
)(
   input  logic [row_width_p-1:0]     row,
   input  logic [set_w_lp-1:0]        set_idx,
   input  logic [way_w_lp-1:0]        way,
   output logic [tag_width_p-1:0]     tag,
   output logic [bp_cce_coh_bits-1:0] state
);

   `BP_CCE_DECLARE_DIR_ENTRY_S(tag_width_p);

   dir_entry_s [tag_sets_per_row_p-1:0][lce_assoc_p-1:0] entries;
   dir_entry_s                                           sel;

   assign entries = row;
   assign sel     = entries[set_idx][way];
   assign tag     = sel.tag;
   assign state   = sel.state;

endmodule

// File: rtl/bp_cce_dir_lru_capture.sv
// Scans the directory rows of one way-group and captures the requesting LCE's LRU entry,
// presenting it on a valid/yumi interface until consumed.
module bp_cce_dir_lru_capture
   import bp_cce_pkg::*;
#(
   parameter int num_lce_p          = 8,
   parameter int lce_assoc_p        = 8,
   parameter int tag_sets_per_row_p = 2,
   parameter int rows_per_wg_p      = 4,
   parameter int tag_width_p        = 20,
   parameter int row_width_p        = tag_sets_per_row_p*lce_assoc_p*(tag_width_p+bp_cce_coh_bits),
   localparam int lce_w_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
   localparam int way_w_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
   localparam int set_bits_lp = $clog2(tag_sets_per_row_p),
   localparam int set_w_lp   = (set_bits_lp > 0) ? set_bits_lp : 1,
   localparam int row_w_lp   = (rows_per_wg_p > 1) ? $clog2(rows_per_wg_p) : 1
)(
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       req_v_i,
   output logic                       req_ready_o,
   input  logic [lce_w_lp-1:0]        req_lce_i,
   input  logic [way_w_lp-1:0]        req_lru_way_i,
   input  logic                       req_mode_i,
   input  logic                       row_v_i,
   output logic                       row_ready_o,
   input  logic [row_width_p-1:0]     row_i,
   input  logic [row_w_lp-1:0]        wg_row_i,
   output logic                       lru_v_o,
   input  logic                       lru_yumi_i,
   output logic [tag_width_p-1:0]     lru_tag_o,
   output logic [bp_cce_coh_bits-1:0] lru_state_o,
   output logic                       lru_cached_excl_o,
   output logic                       lru_cached_dirty_o,
   output logic                       lru_err_o
);

   typedef enum logic [1:0] {e_IDLE, e_SCAN, e_DONE} state_e;

   state_e                       state_r, state_n;
   logic [lce_w_lp-1:0]          lce_r;
   logic [way_w_lp-1:0]          way_r;
   logic                         mode_r;
   logic [row_w_lp-1:0]          cnt_r;
   logic [tag_width_p-1:0]       tag_r;
   logic [bp_cce_coh_bits-1:0]   coh_r;
   logic                         err_r;

   logic                         req_fire, row_fire, row_match, last_row;
   logic [set_w_lp-1:0]          set_idx;
   logic [tag_width_p-1:0]       sel_tag;
   logic [bp_cce_coh_bits-1:0]   sel_state;

   generate
      if (rows_per_wg_p == 1) begin : g_single_row
         assign row_match = 1'b1;
      end else begin : g_multi_row
         assign row_match = (wg_row_i == lce_r[set_bits_lp +: row_w_lp]);
      end
      if (set_bits_lp == 0) begin : g_single_set
         assign set_idx = '0;
      end else begin : g_multi_set
         assign set_idx = lce_r[set_w_lp-1:0];
      end
   endgenerate

   bp_cce_dir_lru_row_select #(
      .lce_assoc_p        (lce_assoc_p),
      .tag_sets_per_row_p (tag_sets_per_row_p),
      .tag_width_p        (tag_width_p),
      .row_width_p        (row_width_p)
   ) row_select (
      .row     (row_i),
      .set_idx (set_idx),
      .way     (way_r),
      .tag     (sel_tag),
      .state   (sel_state)
   );

   assign req_fire = req_v_i & req_ready_o;
   assign row_fire = row_v_i & row_ready_o;
   assign last_row = (cnt_r == row_w_lp'(rows_per_wg_p - 1));

   always_comb begin
      state_n     = state_r;
      req_ready_o = 1'b0;
      row_ready_o = 1'b0;
      lru_v_o     = 1'b0;
      unique case (state_r)
         e_IDLE: begin
            req_ready_o = 1'b1;
            if (req_v_i) state_n = e_SCAN;
         end
         e_SCAN: begin
            row_ready_o = 1'b1;
            if (row_v_i && last_row) state_n = e_DONE;
         end
         e_DONE: begin
            lru_v_o = 1'b1;
            if (lru_yumi_i) state_n = e_IDLE;
         end
         default: state_n = e_IDLE;
      endcase
   end

   // The counter holds on the last row, so it can never wrap within a request.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_IDLE;
         lce_r   <= '0;
         way_r   <= '0;
         mode_r  <= 1'b0;
         cnt_r   <= '0;
         tag_r   <= '0;
         coh_r   <= e_COH_I;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         if (req_fire) begin
            lce_r  <= req_lce_i;
            way_r  <= req_lru_way_i;
            mode_r <= req_mode_i;
            cnt_r  <= '0;
            tag_r  <= '0;
            coh_r  <= e_COH_I;
            err_r  <= 1'b0;
         end else if (row_fire) begin
            if (!last_row) cnt_r <= cnt_r + row_w_lp'(1);
            if (wg_row_i != cnt_r) err_r <= 1'b1;
            if (row_match) begin
               tag_r <= sel_tag;
               coh_r <= sel_state;
            end
         end
      end
   end

   assign lru_tag_o          = tag_r;
   assign lru_state_o        = coh_r;
   assign lru_err_o          = err_r;
   assign lru_cached_dirty_o = (coh_r == e_COH_M);
   assign lru_cached_excl_o  = mode_r ? lru_cached_dirty_o
                                      : ((coh_r != e_COH_I) & ~coh_r[bp_cce_coh_shared_bit]);

   yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                          lru_yumi_i |-> lru_v_o);

endmodule

// File: tb/tb_bp_cce_dir_lru_capture.sv
// Directed scoreboard bench for the LRU capture unit: default 4-row configuration plus a single-row instance.
module tb_bp_cce_dir_lru_capture;
   import bp_cce_pkg::*;

   localparam int ew  = 20 + bp_cce_coh_bits;
   localparam int rw  = 2*8*ew;
   localparam int rwd = 8*8*ew;

   typedef struct {
      logic [19:0] tag;
      logic [2:0]  st;
      logic        excl;
      logic        dirty;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   ncmp = 0;
   int   nfail = 0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_v = 1'b0, req_ready, req_mode = 1'b0;
   logic [2:0]    req_lce = '0, req_way = '0;
   logic          row_v = 1'b0, row_ready;
   logic [rw-1:0] row = '0;
   logic [1:0]    wg_row = '0;
   logic          lru_v, lru_yumi = 1'b0, lru_excl, lru_dirty, lru_err;
   logic [19:0]   lru_tag;
   logic [2:0]    lru_state;

   logic           d_req_v = 1'b0, d_req_ready, d_req_mode = 1'b0;
   logic [2:0]     d_req_lce = '0, d_req_way = '0;
   logic           d_row_v = 1'b0, d_row_ready;
   logic [rwd-1:0] d_row = '0;
   logic           d_wg_row = 1'b0;
   logic           d_lru_v, d_lru_yumi = 1'b0, d_lru_excl, d_lru_dirty, d_lru_err;
   logic [19:0]    d_lru_tag;
   logic [2:0]     d_lru_state;

   logic [rw-1:0] rows [4];

   bp_cce_dir_lru_capture dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_v_i(req_v), .req_ready_o(req_ready), .req_lce_i(req_lce),
      .req_lru_way_i(req_way), .req_mode_i(req_mode),
      .row_v_i(row_v), .row_ready_o(row_ready), .row_i(row), .wg_row_i(wg_row),
      .lru_v_o(lru_v), .lru_yumi_i(lru_yumi), .lru_tag_o(lru_tag), .lru_state_o(lru_state),
      .lru_cached_excl_o(lru_excl), .lru_cached_dirty_o(lru_dirty), .lru_err_o(lru_err)
   );

   bp_cce_dir_lru_capture #(
      .num_lce_p(8), .lce_assoc_p(8), .tag_sets_per_row_p(8), .rows_per_wg_p(1), .tag_width_p(20)
   ) dut_single (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_v_i(d_req_v), .req_ready_o(d_req_ready), .req_lce_i(d_req_lce),
      .req_lru_way_i(d_req_way), .req_mode_i(d_req_mode),
      .row_v_i(d_row_v), .row_ready_o(d_row_ready), .row_i(d_row), .wg_row_i(d_wg_row),
      .lru_v_o(d_lru_v), .lru_yumi_i(d_lru_yumi), .lru_tag_o(d_lru_tag), .lru_state_o(d_lru_state),
      .lru_cached_excl_o(d_lru_excl), .lru_cached_dirty_o(d_lru_dirty), .lru_err_o(d_lru_err)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [19:0] tag, input logic [2:0] st,
                           input logic excl, input logic dirty, input logic err);
      exp_t e;
      e.tag = tag; e.st = st; e.excl = excl; e.dirty = dirty; e.err = err;
      sb.push_back(e);
   endtask

   // Every entry carries a distinct distractor tag so a wrong row/set/way pick shows up.
   task automatic init_rows();
      for (int r = 0; r < 4; r++)
         for (int s = 0; s < 2; s++)
            for (int w = 0; w < 8; w++)
               rows[r][(s*8+w)*ew +: ew] = {20'(r*4096 + s*256 + w*16 + 7), e_COH_S};
   endtask

   task automatic put(input int r, input int s, input int w, input logic [19:0] tag, input logic [2:0] st);
      rows[r][(s*8+w)*ew +: ew] = {tag, st};
   endtask

   task automatic do_req(input logic [2:0] lce, input logic [2:0] way, input logic mode);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("req_ready_idle", req_ready, 1);
      check("row_ready_idle", row_ready, 0);
      req_v = 1'b1; req_lce = lce; req_way = way; req_mode = mode;
      @(negedge clk);
      req_v = 1'b0;
   endtask

   task automatic send_rows(input logic [7:0] ord, input int n, input int gap, input bit spurious);
      for (int i = 0; i < n; i++) begin
         row_v = 1'b1; wg_row = ord[2*i +: 2]; row = rows[ord[2*i +: 2]];
         check("row_ready_scan", row_ready, 1);
         check("v_during_scan", lru_v, 0);
         @(negedge clk);
         row_v = 1'b0; row = '0;
         if (i < n-1) begin
            for (int g = 0; g < gap; g++) begin
               if (spurious) begin req_v = 1'b1; req_lce = 3'd0; req_way = 3'd0; req_mode = ~req_mode; end
               check("req_ready_scan", req_ready, 0);
               @(negedge clk);
               req_v = 1'b0;
            end
         end
      end
   endtask

   task automatic cmp_out(input exp_t e);
      check("tag", lru_tag, e.tag);
      check("state", lru_state, e.st);
      check("excl", lru_excl, e.excl);
      check("dirty", lru_dirty, e.dirty);
      check("err", lru_err, e.err);
   endtask

   task automatic collect(input int hold, input bit spurious);
      exp_t e;
      int n = 0;
      while (lru_v !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("lru_v", lru_v, 1);
      check("latency", n, 0);
      check("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp_out(e);
         for (int h = 0; h < hold; h++) begin
            if (spurious) begin req_v = 1'b1; req_lce = 3'd1; req_way = 3'd1; end
            @(negedge clk);
            req_v = 1'b0;
            check("hold_v", lru_v, 1);
            check("hold_req_ready", req_ready, 0);
            cmp_out(e);
         end
      end
      if (lru_v === 1'b1) begin
         lru_yumi = 1'b1;
         @(negedge clk);
         lru_yumi = 1'b0;
         check("v_after_yumi", lru_v, 0);
         check("req_ready_after_yumi", req_ready, 1);
         check("row_ready_after_yumi", row_ready, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [rwd-1:0] dr;
      exp_t de;

      // Reset state
      #1;
      check("rst_lru_v", lru_v, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_row_ready", row_ready, 0);
      check("rst_tag", lru_tag, 0);
      check("rst_state", lru_state, 0);
      check("rst_flags", {lru_excl, lru_dirty, lru_err}, 0);
      check("rst_d_req_ready", d_req_ready, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic MESI capture of an M entry
      init_rows();
      put(2, 1, 3, 20'h1ABCD, e_COH_M);
      push_exp(20'h1ABCD, e_COH_M, 1, 1, 0);
      do_req(3'd5, 3'd3, 1'b0);
      send_rows(8'b11_10_01_00, 4, 0, 0);
      collect(0, 0);

      // E entry, MESI then MSI decode
      put(2, 1, 3, 20'h2468A, e_COH_E);
      push_exp(20'h2468A, e_COH_E, 1, 0, 0);
      do_req(3'd5, 3'd3, 1'b0);
      send_rows(8'b11_10_01_00, 4, 0, 0);
      collect(0, 0);
      push_exp(20'h2468A, e_COH_E, 0, 0, 0);
      do_req(3'd5, 3'd3, 1'b1);
      send_rows(8'b11_10_01_00, 4, 0, 0);
      collect(0, 0);

      // Row gaps with ignored requests, delayed yumi
      init_rows();
      put(2, 1, 3, 20'h3C3C3, e_COH_M);
      push_exp(20'h3C3C3, e_COH_M, 1, 1, 0);
      do_req(3'd5, 3'd3, 1'b0);
      send_rows(8'b11_10_01_00, 4, 3, 1);
      collect(5, 1);

      // Out-of-order rows: capture still happens, err flagged
      init_rows();
      put(2, 0, 6, 20'h0F00D, e_COH_S);
      push_exp(20'h0F00D, e_COH_S, 0, 0, 1);
      do_req(3'd4, 3'd6, 1'b0);
      send_rows(8'b10_11_01_00, 4, 0, 0);
      collect(0, 0);

      // Matching row never seen: cleared entry with err
      init_rows();
      push_exp(20'h0, e_COH_I, 0, 0, 1);
      do_req(3'd5, 3'd3, 1'b0);
      send_rows(8'b11_11_01_00, 4, 0, 0);
      collect(0, 0);

      // Reset mid-scan discards the request
      init_rows();
      put(1, 1, 2, 20'h77777, e_COH_E);
      do_req(3'd3, 3'd2, 1'b0);
      send_rows(8'b01_00, 2, 0, 0);
      check("tag_pre_reset", lru_tag, 20'h77777);
      reset_n = 1'b0;
      #1;
      check("async_v", lru_v, 0);
      check("async_req_ready", req_ready, 1);
      check("async_row_ready", row_ready, 0);
      check("async_tag", lru_tag, 0);
      check("async_state", lru_state, 0);
      check("async_flags", {lru_excl, lru_dirty, lru_err}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_output_after_reset", lru_v, 0);
      end
      push_exp(20'h77777, e_COH_E, 1, 0, 0);
      do_req(3'd3, 3'd2, 1'b0);
      send_rows(8'b11_10_01_00, 4, 0, 0);
      collect(0, 0);

      // Single-row way-group instance
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 8; w++)
            dr[(s*8+w)*ew +: ew] = {20'(s*16 + w + 100), e_COH_M};
      dr[(7*8+0)*ew +: ew] = {20'h5, e_COH_S};
      push_exp(20'h5, e_COH_S, 0, 0, 0);
      check("d_req_ready", d_req_ready, 1);
      d_req_v = 1'b1; d_req_lce = 3'd7; d_req_way = 3'd0; d_req_mode = 1'b0;
      @(negedge clk);
      d_req_v = 1'b0;
      d_row_v = 1'b1; d_wg_row = 1'b0; d_row = dr;
      check("d_row_ready", d_row_ready, 1);
      @(negedge clk);
      d_row_v = 1'b0; d_row = '0;
      check("d_lru_v", d_lru_v, 1);
      check("d_sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
         de = sb.pop_front();
         check("d_tag", d_lru_tag, de.tag);
         check("d_state", d_lru_state, de.st);
         check("d_excl", d_lru_excl, de.excl);
         check("d_dirty", d_lru_dirty, de.dirty);
         check("d_err", d_lru_err, de.err);
      end
      if (d_lru_v === 1'b1) begin
         d_lru_yumi = 1'b1;
         @(negedge clk);
         d_lru_yumi = 1'b0;
         check("d_v_after_yumi", d_lru_v, 0);
         check("d_req_ready_after_yumi", d_req_ready, 1);
      end

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/bp_cce_dir_lru_capture.md
Name: bp_cce_dir_lru_capture

Overview:
- Sequential LRU-entry capture unit for the CCE directory read path.
- Accepts one LRU lookup request: requesting LCE, LRU way and the coherence-state encoding mode.
- Consumes the multi-cycle stream of directory rows for the way-group and captures the requesting LCE's LRU entry from the matching row.
- Presents tag plus decoded state flags on a valid/yumi output, held until consumed. Replaces single-row, combinational LRU extraction when rows_per_wg_p > 1.

Parameters:
- num_lce_p, 8, number of LCEs tracked by the directory.
- lce_assoc_p, 8, LCE associativity (ways per tag set).
- tag_sets_per_row_p, 2, LCE tag sets per directory row; power of 2.
- rows_per_wg_p, 4, directory rows per way-group; equals num_lce_p/tag_sets_per_row_p.
- tag_width_p, 20, tag bits per directory entry.
- row_width_p, tag_sets_per_row_p*lce_assoc_p*(tag_width_p+bp_cce_coh_bits), row width (derived).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_lce_i  in  clog2(num_lce_p)  requesting LCE.
- req_lru_way_i  in  clog2(lce_assoc_p)  LRU way.
- req_mode_i  in  1  0 = MESI decode, 1 = MSI decode (E treated as S).
- row_v_i  in  1  directory row valid.
- row_ready_o  out  1  row accepted when row_v_i & row_ready_o.
- row_i  in  row_width_p  directory row, packed [set][way]{tag,state}.
- wg_row_i  in  clog2(rows_per_wg_p)  index of row_i within the way-group.
- lru_v_o  out  1  result valid.
- lru_yumi_i  in  1  result consumed; legal only while lru_v_o=1.
- lru_tag_o  out  tag_width_p  captured tag.
- lru_state_o  out  bp_cce_coh_bits  captured coherence state.
- lru_cached_excl_o  out  1  entry held in M or E (MESI mode only).
- lru_cached_dirty_o  out  1  entry held in M.
- lru_err_o  out  1  row-order protocol error seen during the scan.

Behaviour:
- Reset (asynchronous assert, synchronous deassert): state=IDLE, row counter=0, all captured registers 0. Outputs: lru_v_o=0, req_ready_o=1, row_ready_o=0, tag/state/flags/err=0.
- FSM IDLE:
  - req_ready_o=1.
  - Request handshake latches lce, way and mode; clears the captured entry, err and counter; goes to SCAN.
- FSM SCAN:
  - row_ready_o=1 (registered state, no combinational path from row_v_i).
  - Each accepted row: if wg_row_i != counter, set err (sticky for this request).
  - Match test: wg_row_i == lce[offset+:bits], where offset = clog2(tag_sets_per_row_p). When rows_per_wg_p==1, every row matches.
  - On match, capture tag and state from row[lce[0+:clog2(tag_sets_per_row_p)]][way].
  - Counter increments on each accepted row; on the row with counter==rows_per_wg_p-1, go to DONE next cycle.
  - Rows with row_v_i=0 are ignored, so gaps are allowed.
- FSM DONE:
  - lru_v_o=1; outputs are stable from registers.
  - On lru_yumi_i, go to IDLE. req_ready_o=0 in DONE, so back-to-back throughput is one request per rows_per_wg_p+2 cycles.
- Latency: first row may arrive the cycle after request accept; lru_v_o asserts the cycle after the last row is accepted.
- Flag decode:
  - cached_dirty = (state==e_COH_M).
  - cached_excl = (state!=I) & ~state[shared_bit] in MESI mode.
  - In MSI mode: cached_excl = cached_dirty.
  - If no matching row was seen (only possible with an err-flagged stream): tag=0, state=I, flags=0, err=1.
- Boundary rules:
  - Reset mid-SCAN discards the request; no output is produced.
  - req_v_i outside IDLE is not accepted and carries no side effects.
  - Counter wrap is impossible, because the transition to DONE occurs on the last index.
  - rows_per_wg_p==1: counter width 1; the single row completes the scan.
  - lru_yumi_i with lru_v_o=0 is an assertion failure (sim-only check).

Decomposition:
- bp_cce_pkg: the bp_cce_coh_bits, shared-bit and state-encoding constants (e_COH_I/S/E/M), and the dir_entry_s typedef {tag,state} parameterised via macro on tag_width_p.
- Sub-module bp_cce_dir_lru_row_select: combinational selection of the entry from the row given set index and way.
- The FSM, counter and capture registers live in the top.

Test Plan:
- Basic: num_lce_p=8, rows_per_wg_p=4, req lce=5, way=3, MESI. Rows 0..3 in order; row 2 set1 way3 = {tag 0x1ABCD, M} -> lru_v_o one cycle after row 3; tag 0x1ABCD, dirty=1, excl=1, err=0.
- Mode: same setup with state E. MESI gives excl=1, dirty=0; MSI mode (req_mode_i=1) gives excl=0, dirty=0.
- Row gaps and hold: row_v_i deasserted 3 cycles between rows, lru_yumi_i delayed 5 cycles. Outputs are stable while held; req_ready_o=0 until yumi; IDLE the cycle after yumi.
- Order error: rows sent 0,1,3,2 with lce=4 (row 2). Capture still occurs; err=1 at output.
- Reset mid-scan: reset_n_i low after 2 rows. All outputs 0 immediately (async); a new request then completes normally with err=0.
- Degenerate: rows_per_wg_p=1, tag_sets_per_row_p=8, lce=7, way=0 {tag 0x5, S}. Single row -> lru_v_o next cycle, excl=0, dirty=0.
